// File: rtl/gray_code_counter.sv
// Gray-code counter with a binary shadow: up/down stepping, synchronous clear/load,
// wrap or saturate at the ends, registered Gray output that changes one bit per step.
module gray_code_counter #(
    parameter int DATA_WIDTH  = 3,
    parameter int WRAP        = 1,
    parameter int RESET_VALUE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  clr,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_bin,
    output logic [DATA_WIDTH-1:0] gray,
    output logic [DATA_WIDTH-1:0] bin,
    output logic                  wrap,
    output logic                  sat,
    output logic                  at_max,
    output logic                  at_min
);

    localparam logic [DATA_WIDTH-1:0] MAX_BIN   = '1;
    localparam logic [DATA_WIDTH-1:0] RESET_BIN = DATA_WIDTH'(RESET_VALUE);
    localparam logic [DATA_WIDTH-1:0] RESET_GRAY = RESET_BIN ^ (RESET_BIN >> 1);

    logic [DATA_WIDTH-1:0] bin_q, bin_d;
    logic [DATA_WIDTH-1:0] gray_q, gray_d;
    logic                  wrap_q, wrap_d;
    logic                  sat_q, sat_d;

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        sat_d  = 1'b0;
        if (clr) begin
            bin_d = '0;
        end else if (load) begin
            bin_d = load_bin;
        end else if (en) begin
            if (up_dn) begin
                if (bin_q != MAX_BIN) begin
                    bin_d = bin_q + 1'b1;
                end else if (WRAP != 0) begin
                    bin_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    sat_d = 1'b1;
                end
            end else begin
                if (bin_q != '0) begin
                    bin_d = bin_q - 1'b1;
                end else if (WRAP != 0) begin
                    bin_d  = MAX_BIN;
                    wrap_d = 1'b1;
                end else begin
                    sat_d = 1'b1;
                end
            end
        end
        // Gray comes from the next binary value so both registers update together.
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q  <= RESET_BIN;
            gray_q <= RESET_GRAY;
            wrap_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
            sat_q  <= sat_d;
        end
    end

    assign gray   = gray_q;
    assign bin    = bin_q;
    assign wrap   = wrap_q;
    assign sat    = sat_q;
    assign at_max = (bin_q == MAX_BIN);
    assign at_min = (bin_q == '0);

endmodule

// File: tb/tb_gray_code_counter.sv
// Self-checking bench for gray_code_counter: directed scenarios on 3-bit instances
// and a randomized run on 8-bit instances against an arithmetic reference model.
module tb_gray_code_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nCompared   = 0;
    int nMismatched = 0;

    // 3-bit instances share stimulus: A wraps from 0, S saturates from 0, R wraps from 3.
    logic       rst3 = 1'b1, en3 = 1'b0, up3 = 1'b0, clr3 = 1'b0, load3 = 1'b0;
    logic [2:0] lb3 = '0;
    logic [2:0] grayA, binA, grayS, binS, grayR, binR;
    logic       wrapA, satA, maxA, minA, wrapS, satS, maxS, minS, wrapR, satR, maxR, minR;

    // 8-bit instances share random stimulus: W wraps from 8'hA5, T saturates from 0.
    logic       rst8 = 1'b1, en8 = 1'b0, up8 = 1'b0, clr8 = 1'b0, load8 = 1'b0;
    logic [7:0] lb8 = '0;
    logic [7:0] grayW, binW, grayT, binT;
    logic       wrapW, satW, maxW, minW, wrapT, satT, maxT, minT;

    gray_code_counter #(.DATA_WIDTH(3), .WRAP(1), .RESET_VALUE(0)) dutA (
        .clk(clk), .rst(rst3), .en(en3), .up_dn(up3), .clr(clr3), .load(load3), .load_bin(lb3),
        .gray(grayA), .bin(binA), .wrap(wrapA), .sat(satA), .at_max(maxA), .at_min(minA));
    gray_code_counter #(.DATA_WIDTH(3), .WRAP(0), .RESET_VALUE(0)) dutS (
        .clk(clk), .rst(rst3), .en(en3), .up_dn(up3), .clr(clr3), .load(load3), .load_bin(lb3),
        .gray(grayS), .bin(binS), .wrap(wrapS), .sat(satS), .at_max(maxS), .at_min(minS));
    gray_code_counter #(.DATA_WIDTH(3), .WRAP(1), .RESET_VALUE(3)) dutR (
        .clk(clk), .rst(rst3), .en(en3), .up_dn(up3), .clr(clr3), .load(load3), .load_bin(lb3),
        .gray(grayR), .bin(binR), .wrap(wrapR), .sat(satR), .at_max(maxR), .at_min(minR));
    gray_code_counter #(.DATA_WIDTH(8), .WRAP(1), .RESET_VALUE(8'hA5)) dutW (
        .clk(clk), .rst(rst8), .en(en8), .up_dn(up8), .clr(clr8), .load(load8), .load_bin(lb8),
        .gray(grayW), .bin(binW), .wrap(wrapW), .sat(satW), .at_max(maxW), .at_min(minW));
    gray_code_counter #(.DATA_WIDTH(8), .WRAP(0), .RESET_VALUE(0)) dutT (
        .clk(clk), .rst(rst8), .en(en8), .up_dn(up8), .clr(clr8), .load(load8), .load_bin(lb8),
        .gray(grayT), .bin(binT), .wrap(wrapT), .sat(satT), .at_max(maxT), .at_min(minT));

    function automatic int grayOf(input int b);
        return b ^ (b >> 1);
    endfunction

    // Downstream decoder: each binary bit is the XOR of all Gray bits at or above it.
    function automatic int decodeGray(input int g, input int width);
        int b = 0;
        for (int i = 0; i < width; i++) begin
            if ((($countones(g >> i)) % 2) == 1) b |= (1 << i);
        end
        return b;
    endfunction

    function automatic void modelStep(input int cur, input bit up, input bit wrapMode, input int n,
                                      output int nxt, output bit wp, output bit sp);
        int target = up ? cur + 1 : cur - 1;
        wp = 1'b0;
        sp = 1'b0;
        if (target >= 0 && target < n) begin
            nxt = target;
        end else if (wrapMode) begin
            nxt = (target + n) % n;
            wp  = 1'b1;
        end else begin
            nxt = cur;
            sp  = 1'b1;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        nCompared++; if (binA !== 3'd0)     begin nMismatched++; $display("[TB] FAIL reset_binA got %0d want 0", binA); end
        nCompared++; if (grayA !== 3'd0)    begin nMismatched++; $display("[TB] FAIL reset_grayA got %b want 000", grayA); end
        nCompared++; if ({wrapA, satA} !== 2'b00) begin nMismatched++; $display("[TB] FAIL reset_pulsesA got %b want 00", {wrapA, satA}); end
        nCompared++; if ({maxA, minA} !== 2'b01)  begin nMismatched++; $display("[TB] FAIL reset_flagsA got %b want 01", {maxA, minA}); end
        nCompared++; if (binR !== 3'd3)     begin nMismatched++; $display("[TB] FAIL reset_binR got %0d want 3", binR); end
        nCompared++; if (grayR !== 3'b010)  begin nMismatched++; $display("[TB] FAIL reset_grayR got %b want 010", grayR); end
        nCompared++; if ({maxR, minR} !== 2'b00)  begin nMismatched++; $display("[TB] FAIL reset_flagsR got %b want 00", {maxR, minR}); end
        nCompared++; if (binW !== 8'hA5)    begin nMismatched++; $display("[TB] FAIL reset_binW got %h want a5", binW); end
        nCompared++; if (grayW !== 8'(grayOf(8'hA5))) begin nMismatched++; $display("[TB] FAIL reset_grayW got %h want %h", grayW, 8'(grayOf(8'hA5))); end
        @(negedge clk);
        rst3 = 1'b0;
        rst8 = 1'b0;
    endtask

    task automatic test_up_wrap();
        logic [2:0] gTab [0:8];
        gTab = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        nCompared++; if (grayA !== gTab[0]) begin nMismatched++; $display("[TB] FAIL upwrap_gray0 got %b want %b", grayA, gTab[0]); end
        en3 = 1'b1; up3 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            nCompared++; if (grayA !== gTab[i]) begin nMismatched++; $display("[TB] FAIL upwrap_gray step %0d got %b want %b", i, grayA, gTab[i]); end
            nCompared++; if (binA !== 3'(i % 8)) begin nMismatched++; $display("[TB] FAIL upwrap_bin step %0d got %0d want %0d", i, binA, i % 8); end
            nCompared++; if (wrapA !== (i == 8)) begin nMismatched++; $display("[TB] FAIL upwrap_wrap step %0d got %b want %b", i, wrapA, (i == 8)); end
            nCompared++; if (maxA !== (i == 7))  begin nMismatched++; $display("[TB] FAIL upwrap_atmax step %0d got %b want %b", i, maxA, (i == 7)); end
        end
        en3 = 1'b0;
        tick();
        nCompared++; if (wrapA !== 1'b0 || binA !== 3'd0) begin nMismatched++; $display("[TB] FAIL upwrap_hold got bin %0d wrap %b want 0/0", binA, wrapA); end
    endtask

    task automatic test_down_cross_zero();
        logic [2:0] bTab [0:2];
        logic [2:0] gTab [0:2];
        logic       wTab [0:2];
        bTab = '{3'd0, 3'd7, 3'd6};
        gTab = '{3'b000, 3'b100, 3'b101};
        wTab = '{1'b0, 1'b1, 1'b0};
        load3 = 1'b1; lb3 = 3'd1;
        tick();
        load3 = 1'b0;
        nCompared++; if (binA !== 3'd1) begin nMismatched++; $display("[TB] FAIL down_load got %0d want 1", binA); end
        en3 = 1'b1; up3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            nCompared++; if (binA !== bTab[i])  begin nMismatched++; $display("[TB] FAIL down_bin step %0d got %0d want %0d", i, binA, bTab[i]); end
            nCompared++; if (grayA !== gTab[i]) begin nMismatched++; $display("[TB] FAIL down_gray step %0d got %b want %b", i, grayA, gTab[i]); end
            nCompared++; if (wrapA !== wTab[i]) begin nMismatched++; $display("[TB] FAIL down_wrap step %0d got %b want %b", i, wrapA, wTab[i]); end
        end
        en3 = 1'b0;
    endtask

    task automatic test_saturate();
        load3 = 1'b1; lb3 = 3'd6;
        tick();
        load3 = 1'b0;
        en3 = 1'b1; up3 = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            nCompared++; if (binS !== 3'd7)     begin nMismatched++; $display("[TB] FAIL sat_bin step %0d got %0d want 7", i, binS); end
            nCompared++; if (satS !== (i >= 2)) begin nMismatched++; $display("[TB] FAIL sat_pulse step %0d got %b want %b", i, satS, (i >= 2)); end
            nCompared++; if (grayS !== 3'b100)  begin nMismatched++; $display("[TB] FAIL sat_gray step %0d got %b want 100", i, grayS); end
            nCompared++; if (wrapS !== 1'b0)    begin nMismatched++; $display("[TB] FAIL sat_wrap step %0d got %b want 0", i, wrapS); end
        end
        en3 = 1'b0;
    endtask

    task automatic test_priority();
        clr3 = 1'b1; load3 = 1'b1; lb3 = 3'd5; en3 = 1'b1; up3 = 1'b1;
        tick();
        nCompared++; if (binA !== 3'd0 || grayA !== 3'b000) begin nMismatched++; $display("[TB] FAIL prio_clr got bin %0d gray %b want 0/000", binA, grayA); end
        nCompared++; if ({wrapA, satA} !== 2'b00) begin nMismatched++; $display("[TB] FAIL prio_clr_pulse got %b want 00", {wrapA, satA}); end
        nCompared++; if (binS !== 3'd0 || satS !== 1'b0) begin nMismatched++; $display("[TB] FAIL prio_clr_sat got bin %0d sat %b want 0/0", binS, satS); end
        clr3 = 1'b0;
        tick();
        nCompared++; if (binA !== 3'd5 || grayA !== 3'b111) begin nMismatched++; $display("[TB] FAIL prio_load got bin %0d gray %b want 5/111", binA, grayA); end
        nCompared++; if ({wrapA, satA} !== 2'b00) begin nMismatched++; $display("[TB] FAIL prio_load_pulse got %b want 00", {wrapA, satA}); end
        load3 = 1'b0; en3 = 1'b0;
    endtask

    task automatic test_async_reset();
        load3 = 1'b1; lb3 = 3'd7;
        tick();
        load3 = 1'b0; en3 = 1'b1; up3 = 1'b1;
        tick();
        nCompared++; if (wrapR !== 1'b1 || satS !== 1'b1) begin nMismatched++; $display("[TB] FAIL async_pre got wrapR %b satS %b want 1/1", wrapR, satS); end
        #2;
        rst3 = 1'b1;
        #1;
        nCompared++; if (binR !== 3'd3 || grayR !== 3'b010) begin nMismatched++; $display("[TB] FAIL async_R got bin %0d gray %b want 3/010", binR, grayR); end
        nCompared++; if ({wrapR, satR} !== 2'b00) begin nMismatched++; $display("[TB] FAIL async_R_pulse got %b want 00", {wrapR, satR}); end
        nCompared++; if (wrapA !== 1'b0 || satS !== 1'b0) begin nMismatched++; $display("[TB] FAIL async_pulses got wrapA %b satS %b want 0/0", wrapA, satS); end
        @(negedge clk);
        rst3 = 1'b0;
        tick();
        nCompared++; if (binR !== 3'd4) begin nMismatched++; $display("[TB] FAIL async_first_step got %0d want 4", binR); end
        en3 = 1'b0;
    endtask

    task automatic test_random();
        int  mW = 8'hA5, mT = 0;
        int  nW, nT;
        bit  wpW, spW, wpT, spT, enOnly;
        logic [7:0] prevGW, prevGT;
        for (int c = 0; c < 10000; c++) begin
            en8   = ($urandom_range(0, 9) < 7);
            up8   = $urandom_range(0, 1);
            load8 = ($urandom_range(0, 24) == 0);
            clr8  = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 4))
                0:       lb8 = 8'd0;
                1:       lb8 = 8'd255;
                2:       lb8 = 8'd1;
                3:       lb8 = 8'd254;
                default: lb8 = 8'($urandom_range(0, 255));
            endcase
            enOnly = en8 && !load8 && !clr8;
            prevGW = grayW;
            prevGT = grayT;
            wpW = 0; spW = 0; wpT = 0; spT = 0;
            if (clr8) begin
                mW = 0; mT = 0;
            end else if (load8) begin
                mW = int'(lb8); mT = int'(lb8);
            end else if (en8) begin
                modelStep(mW, up8, 1'b1, 256, nW, wpW, spW);
                modelStep(mT, up8, 1'b0, 256, nT, wpT, spT);
                mW = nW; mT = nT;
            end
            tick();
            nCompared++; if (binW !== 8'(mW) || grayW !== 8'(grayOf(mW))) begin nMismatched++; $display("[TB] FAIL rnd_W cyc %0d got bin %h gray %h want %h/%h", c, binW, grayW, 8'(mW), 8'(grayOf(mW))); end
            nCompared++; if (binT !== 8'(mT) || grayT !== 8'(grayOf(mT))) begin nMismatched++; $display("[TB] FAIL rnd_T cyc %0d got bin %h gray %h want %h/%h", c, binT, grayT, 8'(mT), 8'(grayOf(mT))); end
            nCompared++; if ({wrapW, satW, wrapT, satT} !== {wpW, spW, wpT, spT}) begin nMismatched++; $display("[TB] FAIL rnd_pulses cyc %0d got %b want %b", c, {wrapW, satW, wrapT, satT}, {wpW, spW, wpT, spT}); end
            nCompared++; if ({maxW, minW, maxT, minT} !== {mW == 255, mW == 0, mT == 255, mT == 0}) begin nMismatched++; $display("[TB] FAIL rnd_flags cyc %0d got %b want %b", c, {maxW, minW, maxT, minT}, {mW == 255, mW == 0, mT == 255, mT == 0}); end
            nCompared++; if (grayW !== (binW ^ (binW >> 1)) || grayT !== (binT ^ (binT >> 1))) begin nMismatched++; $display("[TB] FAIL rnd_invariant cyc %0d got W %h/%h T %h/%h", c, grayW, binW, grayT, binT); end
            nCompared++; if (decodeGray(int'(grayW), 8) != int'(binW)) begin nMismatched++; $display("[TB] FAIL rnd_decode cyc %0d got %h want %h", c, decodeGray(int'(grayW), 8), binW); end
            if (enOnly) begin
                nCompared++; if ($countones(prevGW ^ grayW) != 1) begin nMismatched++; $display("[TB] FAIL rnd_onebitW cyc %0d got %0d bits want 1", c, $countones(prevGW ^ grayW)); end
                nCompared++; if ($countones(prevGT ^ grayT) != (spT ? 0 : 1)) begin nMismatched++; $display("[TB] FAIL rnd_onebitT cyc %0d got %0d bits want %0d", c, $countones(prevGT ^ grayT), spT ? 0 : 1); end
            end
        end
        en8 = 1'b0; load8 = 1'b0; clr8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_cross_zero();
        test_saturate();
        test_priority();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
